gpio_pad_bank: RTL and testbench

//   Parametrised GPIO bank on the picosoc iomem bus. Sits between the core and the sg13g2 IO pad cells.

---
 rtl/gpio_pad_bank_if.sv | 28 ++
 rtl/gpio_pad_bank.sv | 198 +++++++++++++++++++
 tb/tb_gpio_pad_bank.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_bank_if.sv
// gpio_pad_bank_if: picosoc iomem bus bundle.
// Core side is master, peripheral side is slave.
interface gpio_pad_bank_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid,
      output iomem_wstrb,
      output iomem_addr,
      output iomem_wdata,
      input  iomem_ready,
      input  iomem_rdata
   );

   modport slave (
      input  iomem_valid,
      input  iomem_wstrb,
      input  iomem_addr,
      input  iomem_wdata,
      output iomem_ready,
      output iomem_rdata
   );
endinterface

// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: per-pin direction, output, synchronised and
// debounced input with edge interrupts, on the picosoc iomem bus.
module gpio_pad_bank #(
   parameter int unsigned NPINS       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter int unsigned DBW         = 8
) (
   input  logic             clk,
   input  logic             reset,
   gpio_pad_bank_if.slave   bus,
   input  logic [NPINS-1:0] pad_di,
   output logic [NPINS-1:0] pad_do,
   output logic [NPINS-1:0] pad_oe,
   output logic             irq
);

   localparam logic [7:0] OFF_OUT   = 8'h00;
   localparam logic [7:0] OFF_DIR   = 8'h04;
   localparam logic [7:0] OFF_IN    = 8'h08;
   localparam logic [7:0] OFF_IEN   = 8'h0C;
   localparam logic [7:0] OFF_ISTAT = 8'h10;
   localparam logic [7:0] OFF_IPOL  = 8'h14;
   localparam logic [7:0] OFF_DBNC  = 8'h18;

   logic [NPINS-1:0] out_q, out_d;
   logic [NPINS-1:0] dir_q, dir_d;
   logic [NPINS-1:0] ien_q, ien_d;
   logic [NPINS-1:0] ipol_q, ipol_d;
   logic [NPINS-1:0] istat_q, istat_d;
   logic [DBW-1:0]   dbnc_q, dbnc_d;

   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d;

   logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q, sync_d;
   logic [NPINS-1:0]                  filt_q, filt_d;
   logic [NPINS-1:0]                  fprev_q;
   logic [NPINS-1:0][DBW-1:0]         cnt_q, cnt_d;

   logic             hit;
   logic             wr;
   logic [7:0]       off;
   logic [31:0]      bmask;
   logic [31:0]      rd_val;
   logic             sel_out, sel_dir, sel_in, sel_ien;
   logic             sel_istat, sel_ipol, sel_dbnc;
   logic [31:0]      out_m, dir_m, ien_m, ipol_m, dbnc_m, clr_m;
   logic [NPINS-1:0] clr;
   logic [NPINS-1:0] edge_set;
   logic [NPINS-1:0] src;
   logic [NPINS-1:0] s;
   logic [DBW-1:0]   dbnc_lim;
   logic             dbnc_wr;
   logic             unused_ok;

   // Bus decode: a hit is acknowledged on the following cycle only.
   assign hit     = bus.iomem_valid &&
                    (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign ready_d = hit && !ready_q;
   assign wr      = ready_d && (bus.iomem_wstrb != 4'b0000);
   assign off     = bus.iomem_addr[7:0];

   assign bmask = {{8{bus.iomem_wstrb[3]}},
                   {8{bus.iomem_wstrb[2]}},
                   {8{bus.iomem_wstrb[1]}},
                   {8{bus.iomem_wstrb[0]}}};

   assign sel_out   = (off == OFF_OUT);
   assign sel_dir   = (off == OFF_DIR);
   assign sel_in    = (off == OFF_IN);
   assign sel_ien   = (off == OFF_IEN);
   assign sel_istat = (off == OFF_ISTAT);
   assign sel_ipol  = (off == OFF_IPOL);
   assign sel_dbnc  = (off == OFF_DBNC);

   // Byte-strobed merge of write data into each register.
   assign out_m  = (32'(out_q)  & ~bmask) | (bus.iomem_wdata & bmask);
   assign dir_m  = (32'(dir_q)  & ~bmask) | (bus.iomem_wdata & bmask);
   assign ien_m  = (32'(ien_q)  & ~bmask) | (bus.iomem_wdata & bmask);
   assign ipol_m = (32'(ipol_q) & ~bmask) | (bus.iomem_wdata & bmask);
   assign dbnc_m = (32'(dbnc_q) & ~bmask) | (bus.iomem_wdata & bmask);
   assign clr_m  = bus.iomem_wdata & bmask;

   // Bits above NPINS/DBW are dropped on purpose.
   assign unused_ok = ^{out_m, dir_m, ien_m, ipol_m, dbnc_m, clr_m};

   assign dbnc_wr = wr && sel_dbnc;
   assign clr     = (wr && sel_istat) ? clr_m[NPINS-1:0] : '0;

   // Output pins loop back so driven pins read their own level.
   assign src = (dir_q & out_q) | (~dir_q & pad_di);
   assign s   = sync_q[SYNC_STAGES-1];

   assign edge_set = (filt_q & ~fprev_q & ipol_q) |
                     (~filt_q & fprev_q & ~ipol_q);

   assign dbnc_lim = dbnc_q - DBW'(1);

   // Read mux: unmapped offsets and unused bits read zero.
   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel_out:   rd_val = 32'(out_q);
         sel_dir:   rd_val = 32'(dir_q);
         sel_in:    rd_val = 32'(filt_q);
         sel_ien:   rd_val = 32'(ien_q);
         sel_istat: rd_val = 32'(istat_q);
         sel_ipol:  rd_val = 32'(ipol_q);
         sel_dbnc:  rd_val = 32'(dbnc_q);
         default:   rd_val = '0;
      endcase
   end

   // Register file next state; edge set beats a same-cycle clear.
   always_comb begin
      out_d   = out_q;
      dir_d   = dir_q;
      ien_d   = ien_q;
      ipol_d  = ipol_q;
      dbnc_d  = dbnc_q;
      if (wr) begin
         unique case (1'b1)
            sel_out:  out_d  = out_m[NPINS-1:0];
            sel_dir:  dir_d  = dir_m[NPINS-1:0];
            sel_ien:  ien_d  = ien_m[NPINS-1:0];
            sel_ipol: ipol_d = ipol_m[NPINS-1:0];
            sel_dbnc: dbnc_d = dbnc_m[DBW-1:0];
            default:  ;
         endcase
      end
      istat_d = (istat_q & ~clr) | edge_set;
      irq_d   = |(istat_q & ien_q);
      rdata_d = ready_d ? rd_val : 32'h0;
   end

   // Synchroniser shift and per-pin debounce filter.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], src};
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < NPINS; i++) begin
         if (dbnc_q == '0) begin
            filt_d[i] = s[i];
         end else if (s[i] != filt_q[i]) begin
            if (cnt_q[i] >= dbnc_lim) begin
               filt_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DBW'(1);
            end
         end
      end
      if (dbnc_wr) begin
         cnt_d = '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= '0;
         dir_q   <= '0;
         ien_q   <= '0;
         ipol_q  <= '0;
         istat_q <= '0;
         dbnc_q  <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
         sync_q  <= '0;
         filt_q  <= '0;
         fprev_q <= '0;
         cnt_q   <= '0;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         ien_q   <= ien_d;
         ipol_q  <= ipol_d;
         istat_q <= istat_d;
         dbnc_q  <= dbnc_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
         sync_q  <= sync_d;
         filt_q  <= filt_d;
         fprev_q <= filt_q;
         cnt_q   <= cnt_d;
      end
   end

   assign pad_do          = out_q;
   assign pad_oe          = dir_q;
   assign irq             = irq_q;
   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb_gpio_pad_bank: directed and random checks of gpio_pad_bank
// against a cycle-level behavioural model.
module tb_gpio_pad_bank;
   localparam int NP = 8;
   localparam int SS = 2;
   localparam int DW = 8;
   localparam logic [31:0] BASE = 32'h0300_0000;

   localparam logic [7:0] A_OUT   = 8'h00;
   localparam logic [7:0] A_DIR   = 8'h04;
   localparam logic [7:0] A_IN    = 8'h08;
   localparam logic [7:0] A_IEN   = 8'h0C;
   localparam logic [7:0] A_ISTAT = 8'h10;
   localparam logic [7:0] A_IPOL  = 8'h14;
   localparam logic [7:0] A_DBNC  = 8'h18;

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic [NP-1:0] pad_di = '0;
   logic [NP-1:0] pad_do;
   logic [NP-1:0] pad_oe;
   logic          irq;

   int checks   = 0;
   int failures = 0;

   gpio_pad_bank_if bus ();

   gpio_pad_bank #(
      .NPINS      (NP),
      .SYNC_STAGES(SS),
      .BASE_ADDR  (BASE),
      .DBW        (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .pad_di(pad_di),
      .pad_do(pad_do),
      .pad_oe(pad_oe),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [NP-1:0] m_out   = '0;
   logic [NP-1:0] m_dir   = '0;
   logic [NP-1:0] m_ien   = '0;
   logic [NP-1:0] m_ipol  = '0;
   logic [NP-1:0] m_istat = '0;
   logic [NP-1:0] m_filt  = '0;
   logic [NP-1:0] m_fprev = '0;
   logic [DW-1:0] m_dbnc  = '0;
   logic          m_irq   = 1'b0;
   logic [31:0]   m_rdata = '0;
   logic [NP-1:0] m_hist [SS] = '{default: '0};
   int            m_run  [NP] = '{default: 0};

   // Access the model must apply at the next rising edge
   logic          m_commit = 1'b0;
   logic [7:0]    m_off    = '0;
   logic [3:0]    m_wstrb  = '0;
   logic [31:0]   m_wdata  = '0;

   wire           m_wr  = m_commit && (m_wstrb != 4'b0000);
   wire [NP-1:0]  m_src = (m_dir & m_out) | (~m_dir & pad_di);
   wire [NP-1:0]  m_s   = m_hist[SS-1];
   // Pin whose filtered level changed last cycle to its IPOL level
   wire [NP-1:0]  m_set = (m_filt ^ m_fprev) & ~(m_filt ^ m_ipol);

   function automatic logic [31:0] put(input logic [31:0] old,
                                       input logic [31:0] wd,
                                       input logic [3:0]  ws);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] peek(input logic [7:0] off);
      case (off)
         A_OUT:   return 32'(m_out);
         A_DIR:   return 32'(m_dir);
         A_IN:    return 32'(m_filt);
         A_IEN:   return 32'(m_ien);
         A_ISTAT: return 32'(m_istat);
         A_IPOL:  return 32'(m_ipol);
         A_DBNC:  return 32'(m_dbnc);
         default: return 32'h0;
      endcase
   endfunction

   // Model: delay line, stable-run debounce, edge flags, registers
   always @(posedge clk) begin
      if (reset) begin
         m_out   <= '0;
         m_dir   <= '0;
         m_ien   <= '0;
         m_ipol  <= '0;
         m_istat <= '0;
         m_filt  <= '0;
         m_fprev <= '0;
         m_dbnc  <= '0;
         m_irq   <= 1'b0;
         m_rdata <= '0;
         for (int k = 0; k < SS; k++) m_hist[k] <= '0;
         for (int i = 0; i < NP; i++) m_run[i] <= 0;
      end else begin
         m_hist[0] <= m_src;
         for (int k = 1; k < SS; k++) m_hist[k] <= m_hist[k-1];
         for (int i = 0; i < NP; i++) begin
            if (m_dbnc == '0) begin
               m_filt[i] <= m_s[i];
               m_run[i]  <= 0;
            end else if (m_s[i] == m_filt[i]) begin
               m_run[i] <= 0;
            end else if (m_run[i] + 1 >= int'(m_dbnc)) begin
               m_filt[i] <= m_s[i];
               m_run[i]  <= 0;
            end else begin
               m_run[i] <= m_run[i] + 1;
            end
            if (m_wr && m_off == A_DBNC) m_run[i] <= 0;
         end
         m_fprev <= m_filt;
         m_irq   <= |(m_istat & m_ien);
         m_rdata <= (m_commit && m_wstrb == 4'b0000) ?
                    peek(m_off) : 32'h0;
         m_istat <= (m_istat & ~((m_wr && m_off == A_ISTAT) ?
                    NP'(put(32'h0, m_wdata, m_wstrb)) : NP'(0)))
                    | m_set;
         if (m_wr) begin
            case (m_off)
               A_OUT:  m_out  <= NP'(put(32'(m_out), m_wdata, m_wstrb));
               A_DIR:  m_dir  <= NP'(put(32'(m_dir), m_wdata, m_wstrb));
               A_IEN:  m_ien  <= NP'(put(32'(m_ien), m_wdata, m_wstrb));
               A_IPOL: m_ipol <= NP'(put(32'(m_ipol), m_wdata, m_wstrb));
               A_DBNC: m_dbnc <= DW'(put(32'(m_dbnc), m_wdata, m_wstrb));
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("pad_do", 32'(pad_do), 32'(m_out));
      chk("pad_oe", 32'(pad_oe), 32'(m_dir));
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic acc(input logic [31:0] addr, input logic [3:0] ws,
                      input logic [31:0] wd, input bit hold,
                      output logic [31:0] rd);
      logic hit;
      hit = (addr[31:8] == BASE[31:8]);
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = addr;
      bus.iomem_wstrb = ws;
      bus.iomem_wdata = wd;
      m_commit = hit;
      m_off    = addr[7:0];
      m_wstrb  = ws;
      m_wdata  = wd;
      tick();
      m_commit = 1'b0;
      chk("ready", 32'(bus.iomem_ready), 32'(hit));
      if (!hit || ws == 4'b0000)
         chk("rdata", bus.iomem_rdata, m_rdata);
      rd = bus.iomem_rdata;
      if (!hold) bus.iomem_valid = 1'b0;
      tick();
      chk("ready_pulse", 32'(bus.iomem_ready), 32'h0);
      bus.iomem_valid = 1'b0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [3:0] ws,
                     input logic [31:0] wd);
      logic [31:0] v;
      acc(BASE | 32'(off), ws, wd, 1'b0, v);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] v);
      acc(BASE | 32'(off), 4'b0000, 32'h0, 1'b0, v);
   endtask

   logic [31:0] v;
   logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C,
                             8'h10, 8'h14, 8'h18, 8'h1C};

   initial begin
      bus.iomem_valid = 1'b0;
      bus.iomem_addr  = '0;
      bus.iomem_wstrb = '0;
      bus.iomem_wdata = '0;

      // 1: reset state
      repeat (3) tick();
      chk("rst_do", 32'(pad_do), 32'h0);
      chk("rst_oe", 32'(pad_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      for (int k = 0; k < 7; k++) begin
         rd(offs[k], v);
         chk("rst_reg", v, 32'h0);
      end

      // 2: OUT/DIR writes, ready held valid, upper-bit writes ignored
      acc(BASE | 32'(A_OUT), 4'b0001, 32'h0000_00A5, 1'b1, v);
      wr(A_DIR, 4'b0001, 32'hFFFF_FFFF);
      chk("pad_do_a5", 32'(pad_do), 32'h0000_00A5);
      chk("pad_oe_ff", 32'(pad_oe), 32'h0000_00FF);
      wr(A_OUT, 4'b0010, 32'hFFFF_FF5A);
      rd(A_OUT, v);
      chk("out_strb", v, 32'h0000_00A5);
      rd(A_DIR, v);
      chk("dir_rd", v, 32'h0000_00FF);

      // 3: bypass debounce, latency and irq
      wr(A_DIR, 4'b1111, 32'h0);
      repeat (4) tick();
      wr(A_ISTAT, 4'b0001, 32'hFF);
      wr(A_IPOL, 4'b0001, 32'h08);
      wr(A_IEN, 4'b0001, 32'h08);
      pad_di[3] = 1'b1;
      tick();
      tick();
      rd(A_IN, v);
      chk("in_lat_early", v, 32'h0);
      rd(A_IN, v);
      chk("in_lat", v, 32'h08);
      rd(A_ISTAT, v);
      chk("istat3", v, 32'h08);
      chk("irq_set", 32'(irq), 32'h1);
      wr(A_ISTAT, 4'b0001, 32'h08);
      chk("irq_clr", 32'(irq), 32'h0);

      // 4: debounce of 4 cycles
      wr(A_DBNC, 4'b0001, 32'h4);
      wr(A_IPOL, 4'b0001, 32'h09);
      pad_di[0] = 1'b1;
      repeat (3) tick();
      pad_di[0] = 1'b0;
      repeat (10) tick();
      rd(A_IN, v);
      chk("glitch_in", v, 32'h08);
      rd(A_ISTAT, v);
      chk("glitch_istat", v, 32'h0);
      pad_di[0] = 1'b1;
      repeat (6) tick();
      pad_di[0] = 1'b0;
      rd(A_IN, v);
      chk("pulse_in", v, 32'h09);
      repeat (10) tick();
      rd(A_IN, v);
      chk("pulse_in_end", v, 32'h08);
      rd(A_ISTAT, v);
      chk("pulse_istat", v, 32'h01);

      // 5: edge coincident with W1C, partial W1C, window misses
      wr(A_ISTAT, 4'b0001, 32'h01);
      wr(A_DBNC, 4'b0001, 32'h0);
      tick();
      tick();
      pad_di[0] = 1'b1;
      repeat (3) tick();
      wr(A_ISTAT, 4'b0001, 32'h01);
      rd(A_ISTAT, v);
      chk("set_wins", v, 32'h01);
      wr(A_ISTAT, 4'b0010, 32'hFFFF_FFFF);
      rd(A_ISTAT, v);
      chk("w1c_strb", v, 32'h01);
      wr(A_ISTAT, 4'b0001, 32'h01);
      rd(A_ISTAT, v);
      chk("w1c", v, 32'h0);
      acc(BASE + 32'h100, 4'b0000, 32'h0, 1'b0, v);
      chk("miss_rd", v, 32'h0);
      rd(8'h40, v);
      chk("hole_rd", v, 32'h0);

      // Random traffic against the model
      wr(A_DBNC, 4'b0001, 32'($urandom_range(0, 3)));
      wr(A_IEN, 4'b0001, 32'($urandom));
      wr(A_IPOL, 4'b0001, 32'($urandom));
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0)
            pad_di = pad_di ^ NP'(1 << $urandom_range(0, NP-1));
         case ($urandom_range(0, 9))
            0: begin
               int k;
               k = $urandom_range(0, 7);
               if (offs[k] == A_DBNC)
                  wr(offs[k], 4'($urandom), 32'($urandom_range(0, 5)));
               else
                  wr(offs[k], 4'($urandom), $urandom);
            end
            1, 2: rd(offs[$urandom_range(0, 7)], v);
            default: tick();
         endcase
      end

      // 6: reset while a request is pending
      pad_di = '0;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = BASE | 32'(A_OUT);
      bus.iomem_wstrb = 4'b0001;
      bus.iomem_wdata = 32'hFF;
      reset = 1'b1;
      tick();
      chk("rst_noready", 32'(bus.iomem_ready), 32'h0);
      tick();
      chk("rst_noready2", 32'(bus.iomem_ready), 32'h0);
      bus.iomem_valid = 1'b0;
      reset = 1'b0;
      chk("rst2_irq", 32'(irq), 32'h0);
      chk("rst2_oe", 32'(pad_oe), 32'h0);
      for (int k = 0; k < 7; k++) begin
         rd(offs[k], v);
         chk("rst2_reg", v, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
